// File: rtl/voice_udp_packer_if.sv
// Byte-stream bus between the voice packet builder and the UDP transmit core.
// The packer drives the request/length and the byte stream (master); the UDP
// core answers with the request acknowledge and per-byte ready (slave).
//   tx_req   : packet ready, held until tx_ack is seen
//   tx_len   : UDP payload length in bytes (header + line), stable while tx_req
//   tx_ack   : UDP core accepts the request
//   tx_data  : payload byte
//   tx_valid : tx_data valid
//   tx_last  : final byte of the packet, qualified by tx_valid
//   tx_ready : byte consumed when tx_valid & tx_ready
interface voice_udp_packer_if;
  logic        tx_req;
  logic [15:0] tx_len;
  logic        tx_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;

  modport master (
    output tx_req, tx_len, tx_data, tx_valid, tx_last,
    input  tx_ack, tx_ready
  );

  modport slave (
    input  tx_req, tx_len, tx_data, tx_valid, tx_last,
    output tx_ack, tx_ready
  );
endinterface

// File: rtl/voice_udp_packer.sv
// voice_udp_packer
// Captures each href line of the voice cache stage into one of two ping-pong
// banks and sends every committed line to the UDP core as one payload:
// a 4-byte header {MAGIC, flags, seq, line_idx} followed by the line bytes.
// Ports:
//   sck         : clock shared with the voice cache stage
//   rst         : asynchronous, active-low reset
//   voice_vsync : frame sync, clears the line index (aborts a line in flight)
//   voice_href  : line valid, one byte per cycle while high
//   voice_data  : line byte
//   tx          : request + byte-stream bus to the UDP core (master side)
//   drop_cnt    : lines dropped because both banks were committed (saturating)
//   busy        : a bank is committed or a packet is being sent
module voice_udp_packer #(
  parameter int          LINE_BYTES = 1024,
  parameter int          ADDR_W     = 10,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                sck,
  input  logic                rst,
  input  logic                voice_vsync,
  input  logic                voice_href,
  input  logic [7:0]          voice_data,
  voice_udp_packer_if.master  tx,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  // Byte counter needs one extra bit so a completely full bank can be counted.
  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LINE_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_PAY, S_DONE} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Write side state
  logic             href_p1;
  logic             wr_active;
  logic             wr_bank;
  logic [CNT_W-1:0] wcnt;
  logic             wovf;
  logic [7:0]       line_idx;
  logic [1:0]       committed;

  // Per-bank line descriptors, only read while the bank is committed
  logic [CNT_W-1:0] bank_len [2];
  logic [7:0]       bank_idx [2];
  logic             bank_ovf [2];

  // Read side state
  state_t           state_q, state_d;
  logic             rd_bank;
  logic [1:0]       hdr_cnt;
  logic [CNT_W-1:0] pay_cnt;
  logic [CNT_W-1:0] rd_len;
  logic [7:0]       seq;
  logic [15:0]      tx_len_q;

  logic [7:0]       mem [2**(ADDR_W+1)];
  logic [7:0]       ram_q_p1;

  logic             rise, fall, claim, drop, abort, commit, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic             accept, last_byte, hdr_end, pay_end, rd_en, rel;
  logic [CNT_W-1:0] pay_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]       hdr_byte;

  // ---- stage p0: href edge detection and line claim/commit decisions ----
  assign rise   = voice_href & ~href_p1;
  assign fall   = ~voice_href & href_p1;
  // A rising href coinciding with vsync never starts a line.
  assign claim  = rise & ~voice_vsync & ~committed[wr_bank];
  assign drop   = rise & ~voice_vsync &  committed[wr_bank];
  assign abort  = wr_active & voice_href & voice_vsync;
  assign commit = wr_active & fall;
  // The claiming cycle already carries byte 0; bytes past the bank end are discarded.
  assign wr_en   = voice_href & ~voice_vsync & (claim | (wr_active & (wcnt < MAX_CNT)));
  assign wr_addr = claim ? '0 : wcnt[ADDR_W-1:0];

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      href_p1   <= 1'b0;
      wr_active <= 1'b0;
      wr_bank   <= 1'b0;
      wcnt      <= '0;
      wovf      <= 1'b0;
      line_idx  <= 8'd0;
      committed <= 2'b00;
      drop_cnt  <= 16'd0;
    end else begin
      href_p1 <= voice_href;
      if (claim) begin
        wr_active <= 1'b1;
        wcnt      <= CNT_W'(1);
        wovf      <= 1'b0;
      end else if (abort || commit) begin
        wr_active <= 1'b0;
      end else if (wr_active && voice_href) begin
        if (wcnt < MAX_CNT) wcnt <= wcnt + CNT_W'(1);
        else                wovf <= 1'b1;
      end
      if (drop) drop_cnt <= sat_inc16(drop_cnt);
      if (voice_vsync)  line_idx <= 8'd0;
      else if (commit)  line_idx <= line_idx + 8'd1;
      if (commit) wr_bank <= ~wr_bank;
      // Release and commit always target different banks: the bank being
      // written was free when claimed, the bank being released is committed.
      if (rel)    committed[rd_bank] <= 1'b0;
      if (commit) committed[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge sck) begin
    if (commit) begin
      bank_len[wr_bank] <= wcnt;
      bank_idx[wr_bank] <= line_idx;
      bank_ovf[wr_bank] <= wovf;
    end
  end

  // ---- stage p1: bank RAM, synchronous write and 1-cycle read ----
  // The next payload byte is fetched only on the accepting cycle, so the RAM
  // output register holds the presented byte stable through back-pressure.
  assign accept    = tx.tx_valid & tx.tx_ready;
  assign last_byte = (pay_cnt == rd_len - CNT_W'(1));
  assign hdr_end   = (state_q == S_HDR) & accept & (hdr_cnt == 2'd3);
  assign pay_end   = (state_q == S_PAY) & accept & last_byte;
  assign pay_nxt   = pay_cnt + CNT_W'(1);
  assign rd_en     = hdr_end | ((state_q == S_PAY) & accept & ~last_byte);
  assign rd_addr   = hdr_end ? '0 : pay_nxt[ADDR_W-1:0];
  assign rel       = (state_q == S_DONE);

  always_ff @(posedge sck) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= voice_data;
    if (rd_en) ram_q_p1 <= mem[{rd_bank, rd_addr}];
  end

  // ---- read FSM: state register ----
  always_ff @(posedge sck or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---- read FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (committed[rd_bank]) state_d = S_REQ;
      S_REQ:  if (tx.tx_ack)          state_d = S_HDR;
      S_HDR:  if (hdr_end)            state_d = S_PAY;
      S_PAY:  if (pay_end)            state_d = S_DONE;
      S_DONE:                         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // ---- read FSM: packet bookkeeping ----
  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      rd_bank  <= 1'b0;
      hdr_cnt  <= 2'd0;
      pay_cnt  <= '0;
      rd_len   <= '0;
      seq      <= 8'd0;
      tx_len_q <= 16'd0;
    end else begin
      if (state_q == S_IDLE && committed[rd_bank]) begin
        tx_len_q <= 16'(bank_len[rd_bank]) + 16'd4;
        rd_len   <= bank_len[rd_bank];
        hdr_cnt  <= 2'd0;
        pay_cnt  <= '0;
      end
      if (state_q == S_HDR && accept) hdr_cnt <= hdr_cnt + 2'd1;
      if (state_q == S_PAY && accept) pay_cnt <= pay_nxt;
      if (state_q == S_DONE) begin
        rd_bank <= ~rd_bank;
        seq     <= seq + 8'd1;
      end
    end
  end

  always_comb begin
    case (hdr_cnt)
      2'd0:    hdr_byte = MAGIC;
      2'd1:    hdr_byte = {(bank_idx[rd_bank] == 8'd0), bank_ovf[rd_bank], 6'b0};
      2'd2:    hdr_byte = seq;
      default: hdr_byte = bank_idx[rd_bank];
    endcase
  end

  // ---- read FSM: outputs ----
  always_comb begin
    tx.tx_req   = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'd0;
    tx.tx_last  = 1'b0;
    case (state_q)
      S_REQ: tx.tx_req = 1'b1;
      S_HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = hdr_byte;
      end
      S_PAY: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = ram_q_p1;
        tx.tx_last  = last_byte;
      end
      default: ;
    endcase
  end

  assign tx.tx_len = tx_len_q;
  assign busy      = committed[0] | committed[1] | (state_q != S_IDLE);

endmodule

// File: doc/voice_udp_packer.md
Name: voice_udp_packer

Overview:
- Consumes the 8-bit line stream of the voice cache stage (voice_vsync, voice_href, ldata_out) in the sck domain.
- Stores each href line in a two-bank ping-pong buffer.
- Emits one UDP payload per line to the UDP transmit core: a 4-byte header followed by the line bytes, over a start handshake and a valid/ready byte stream.

Parameters:
LINE_BYTES, 1024, maximum payload bytes per line; equals the cache stage HREF_WIDTH.
ADDR_W, 10, bank address width; 2^ADDR_W >= LINE_BYTES.
MAGIC, 8'hA5, header byte 0.

Ports:
sck  input  1  clock, shared with the voice cache stage
rst  input  1  reset, asynchronous, active-low
voice_vsync  input  1  frame sync; resets the line index
voice_href  input  1  line valid; one data byte per sck cycle while high
voice_data  input  8  line byte, valid when voice_href=1
tx_req  output  1  packet ready, request to the UDP core
tx_len  output  16  UDP payload length in bytes, stable while tx_req=1
tx_ack  input  1  UDP core accepts the request
tx_data  output  8  payload byte
tx_valid  output  1  tx_data valid
tx_last  output  1  final byte of the packet, qualified by tx_valid
tx_ready  input  1  UDP core consumes the byte when tx_valid&tx_ready
drop_cnt  output  16  lines dropped because no bank was free; saturates at 16'hFFFF
busy  output  1  at least one bank committed or a packet in progress

Behaviour:
- Reset: rst is asynchronous, active-low. While rst=0 all outputs are 0, both banks are free, seq=0, line_idx=0, write bank=0. Reset mid-packet aborts the packet immediately, with no tx_last.
- Write side:
  - A rising voice_href claims the current write bank if it is free. If both banks are committed, the whole line is dropped and drop_cnt increments once.
  - Each href-high cycle writes voice_data at waddr and increments waddr.
  - Bytes past LINE_BYTES are discarded and the bank's overflow flag is set.
  - Falling voice_href commits the bank with len = min(bytes, LINE_BYTES), line_idx and overflow stored per bank, then toggles the write bank and increments line_idx (8-bit, wraps).
  - voice_vsync=1 sets line_idx=0. If vsync is asserted while href is high, the current line is aborted: the bank stays free and line_idx is not incremented.
- Read FSM (IDLE, REQ, HDR, PAY, DONE):
  - IDLE -> REQ when the read bank (oldest committed) is committed. tx_len = len+4 is registered at the same edge.
  - REQ: tx_req=1 until tx_ack is sampled high, then HDR. tx_req deasserts on the cycle after tx_ack.
  - HDR: 4 bytes, each advanced on tx_valid&tx_ready:
    - byte 0: MAGIC
    - byte 1: {frame_start, overflow, 6'b0}, where frame_start = (stored line_idx==0)
    - byte 2: seq
    - byte 3: stored line_idx
  - PAY: bank bytes in address order 0..len-1, read from synchronous RAM with 1-cycle read latency.
    - tx_valid may drop for bubbles.
    - A byte presented with tx_valid=1 holds data stable until tx_ready.
    - tx_last=1 on byte len-1.
  - DONE: free the bank, toggle the read bank, seq++ (8-bit wrap 255->0), return to IDLE. DONE lasts 1 cycle.
- Simultaneous events:
  - A bank release and a new line claim in the same cycle are legal. The claim sees the bank as still committed, so the line drops only if the other bank is also committed.
  - A write commit and a read start on different banks in the same cycle are independent.
- Ordering: packets leave in commit order, with no reordering.
- busy = (bank0 committed | bank1 committed | FSM != IDLE).

Test Plan:
- Single line: vsync 32 cycles, then href 1024 cycles with data = addr[7:0], tx_ready=1, ack after 3 cycles. Required: tx_len=1028; header A5,80,00,00; payload 00..FF repeating; tx_last on the 1028th byte; busy returns to 0.
- Back-pressure: same line with tx_ready toggling 1,0,0,1 per cycle. Required: byte sequence identical to the single-line case; no duplicate or lost bytes; tx_data stable while tx_valid&!tx_ready.
- Overflow and short line:
  - Line of 1030 bytes: tx_len=1028, flags byte 0xC0 (frame_start + overflow).
  - Next line of 10 bytes: tx_len=14, flags 0x00, line_idx=01, seq=01.
- Drop: hold tx_ack=0 and send 3 lines. Required: lines 0 and 1 committed, line 2 dropped, drop_cnt=1. After acks, packets for line_idx 0 then 1 with seq 0,1.
- Seq wrap and vsync: 257 lines with vsync between every 4 lines. Required: seq goes 255 then 00; line_idx resets to 0 after each vsync; flags bit7 set on every 4th packet.
- Reset mid-PAY: drop rst after 100 payload bytes. Required: outputs 0 asynchronously. After release, a new line yields seq=00 and line_idx=00.
